adc_idelay_calib_ctrl: RTL and testbench
========================================

Name: adc_idelay_calib_ctrl

Overview:
- Sequencer that trains the per-lane input delay taps of the AD9643 LVDS receiver.
- On start it sweeps one common tap value across all data lanes.
- At each tap it checks the ADC ramp test pattern and records pass/fail per lane.
- It then loads each lane with the centre of that lane's widest passing window. It sits in the 200 MHz delay-clock domain, between the AXI-lite control register (start/status) and the IDELAY tap inputs.

Parameters:
- DATA_WIDTH, 14: ADC word width; one lane per bit.
- TAP_WIDTH, 5: delay tap width. TAPS = 2**TAP_WIDTH.
- SETTLE, 16: cycles to wait after a tap load before checking.
- SAMPLES, 64: valid-sample comparisons per tap.
- MIN_WINDOW, 4: minimum passing-run length for a lane to be considered locked.
- TIMEOUT, 1024: maximum consecutive cycles without adc_valid while in CHECK.

Ports:
- clk  in  1  delay clock (200 MHz).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that starts calibration.
- idelay_rdy  in  1  IDELAYCTRL ready.
- adc_valid  in  1  adc_data qualifier.
- adc_data  in  DATA_WIDTH  deserialised ADC word (ramp test pattern expected).
- tap_value  out  DATA_WIDTH*TAP_WIDTH  per-lane tap; lane i occupies bits [i*TAP_WIDTH +: TAP_WIDTH].
- tap_load  out  1  one-cycle load strobe, applies to all lanes.
- busy  out  1  high from the cycle after start until done.
- done  out  1  level; held until the next accepted start.
- lane_fail  out  DATA_WIDTH  lane has no window of at least MIN_WINDOW.
- timeout  out  1  sweep aborted because adc_valid was absent.

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Reset values:
  - tap_value = 0, tap_load = 0, busy = 0, done = 0, lane_fail = 0, timeout = 0.
  - Pass map cleared; state = IDLE.
  - Reset mid-sweep returns to these values on the next edge.
- States: IDLE → WAIT_RDY → LOAD → SETTLE → CHECK → NEXT → ANALYZE → APPLY → DONE.
- IDLE:
  - start accepted → WAIT_RDY; busy = 1; done, lane_fail and timeout cleared; tap counter = 0.
  - start is ignored in every other state.
- WAIT_RDY: stays until idelay_rdy = 1, then → LOAD.
- LOAD (1 cycle):
  - All lane fields of tap_value = tap counter; tap_load = 1.
  - → SETTLE with a SETTLE-cycle down-counter.
- CHECK:
  - The first valid sample only seeds prev.
  - Each subsequent valid sample: err_acc |= adc_data ^ (prev + 1) mod 2**DATA_WIDTH; prev = adc_data.
  - After SAMPLES comparisons → NEXT.
  - An idle counter resets on every adc_valid. If it reaches TIMEOUT → abort: timeout = 1, lane_fail = all ones, tap_value = 0, tap_load pulses once, → DONE.
- NEXT:
  - pass_map[lane][tap] = ~err_acc[lane]; err_acc cleared.
  - If tap = TAPS-1 → ANALYZE, else tap++ → LOAD.
- ANALYZE:
  - One tap per cycle per lane, lanes sequential: DATA_WIDTH*TAPS cycles.
  - Tracks run start, run length, best start and best length. Runs do not wrap from tap TAPS-1 to 0.
  - Ties: the earliest run wins (replace only on strictly longer).
- Per-lane result:
  - If best length >= MIN_WINDOW: tap = best_start + (best_len-1)/2 (floor).
  - Otherwise tap = 0 and lane_fail[lane] = 1.
- APPLY (1 cycle): tap_value = per-lane results; tap_load = 1.
- DONE: busy = 0, done = 1 → IDLE. Outputs are held.
- Nominal latency: TAPS*(1 + SETTLE + ≥SAMPLES+1 + 1) + DATA_WIDTH*TAPS + 3 cycles.

Test Plan:
- Ideal ramp, adc_valid = 1 continuously, all taps clean → every lane tap = 15 (window 0..31); lane_fail = 0; tap_load pulsed 33 times; done = 1.
- Bit 3 inverted for taps 0..9 and 26..31 → lane 3 tap = 17 (window 10..25); all other lanes 15; lane_fail = 0.
- Bit 5 clean only at taps 4..6 (length 3 < 4) → lane 5 tap = 0; lane_fail = 0x0020; other lanes 15.
- Bit 0 clean at taps 2..7 and 20..25 (equal length 6) → lane 0 tap = 4 (earliest run).
- idelay_rdy = 0 for 100 cycles after start → no tap_load until it rises, then normal completion. Separately: adc_valid held low in CHECK for 1024 cycles → timeout = 1, lane_fail = 0x3FFF, taps 0, done = 1.
- Reset asserted mid-CHECK at tap 12 → next cycle all outputs at reset values. A new start runs a full sweep from tap 0 with results identical to scenario 1. A second start pulse while busy has no effect.

Source files
------------

// File: rtl/adc_idelay_calib_ctrl.sv
// adc_idelay_calib_ctrl: trains per-lane IDELAY taps by sweeping a common tap, checking the ramp pattern and centring each lane in its widest passing window
// Ports: clk/reset (sync, active-high); start pulse; idelay_rdy; adc_valid/adc_data ramp input;
//        tap_value/tap_load to the IDELAYs; busy/done/lane_fail/timeout status.
module adc_idelay_calib_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int TAP_WIDTH  = 5,
  parameter int SETTLE     = 16,
  parameter int SAMPLES    = 64,
  parameter int MIN_WINDOW = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            idelay_rdy,
  input  logic                            adc_valid,
  input  logic [DATA_WIDTH-1:0]           adc_data,
  output logic [DATA_WIDTH*TAP_WIDTH-1:0] tap_value,
  output logic                            tap_load,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH-1:0]           lane_fail,
  output logic                            timeout
);
  localparam int TAPS = 2**TAP_WIDTH;
  localparam int LW = TAP_WIDTH + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = $clog2(SAMPLES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int NW = $clog2(DATA_WIDTH + 1);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST = TAP_WIDTH'(TAPS - 1);
  localparam logic [NW-1:0] LANE_LAST = NW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);
  localparam logic [LW-1:0] MIN_LEN = LW'(MIN_WINDOW);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_ANALYZE, S_APPLY, S_DONE
  } state_t;

  state_t state, nxt;
  logic [TAP_WIDTH-1:0] tap, atap, run_start, best_start, cur_start, fin_start, fin_tap;
  logic [LW-1:0] run_len, best_len, cur_len, fin_len;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] samp_cnt;
  logic [IW-1:0] idle_cnt;
  logic [NW-1:0] lane;
  logic seeded, p, better, fin_ok, abort;
  logic [DATA_WIDTH-1:0] prev, err_acc;
  logic [DATA_WIDTH-1:0][TAPS-1:0] pass_map;
  logic [DATA_WIDTH*TAP_WIDTH-1:0] result;

  always_comb begin
    nxt = state;
    abort = 1'b0;
    p = pass_map[lane][atap];
    cur_len = p ? run_len + LW'(1) : '0;
    cur_start = (p && run_len == '0) ? atap : run_start;
    // strictly longer replaces, so the earliest of equal runs is kept
    better = p && (cur_len > best_len);
    fin_len = better ? cur_len : best_len;
    fin_start = better ? cur_start : best_start;
    fin_ok = fin_len >= MIN_LEN;
    fin_tap = fin_ok ? fin_start + TAP_WIDTH'((fin_len - LW'(1)) >> 1) : '0;
    case (state)
      S_IDLE:     nxt = start ? S_WAIT_RDY : S_IDLE;
      S_WAIT_RDY: nxt = idelay_rdy ? S_LOAD : S_WAIT_RDY;
      S_LOAD:     nxt = S_SETTLE;
      S_SETTLE:   nxt = (settle_cnt == '0) ? S_CHECK : S_SETTLE;
      S_CHECK: begin
        if (adc_valid && seeded && samp_cnt == SAMP_LAST) nxt = S_NEXT;
        else if (!adc_valid && idle_cnt == IDLE_LAST) begin
          abort = 1'b1;
          nxt = S_DONE;
        end
      end
      S_NEXT:     nxt = (tap == TAP_LAST) ? S_ANALYZE : S_LOAD;
      S_ANALYZE:  nxt = (atap == TAP_LAST && lane == LANE_LAST) ? S_APPLY : S_ANALYZE;
      S_APPLY:    nxt = S_DONE;
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      tap_value <= '0;
      tap_load <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      lane_fail <= '0;
      timeout <= 1'b0;
      pass_map <= '0;
      result <= '0;
      tap <= '0;
      atap <= '0;
      lane <= '0;
      run_start <= '0;
      run_len <= '0;
      best_start <= '0;
      best_len <= '0;
      settle_cnt <= '0;
      samp_cnt <= '0;
      idle_cnt <= '0;
      seeded <= 1'b0;
      prev <= '0;
      err_acc <= '0;
    end else begin
      state <= nxt;
      tap_load <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          done <= 1'b0;
          lane_fail <= '0;
          timeout <= 1'b0;
          tap <= '0;
          err_acc <= '0;
        end
        S_LOAD: begin
          tap_value <= {DATA_WIDTH{tap}};
          tap_load <= 1'b1;
          settle_cnt <= SETTLE_INIT;
          seeded <= 1'b0;
          samp_cnt <= '0;
          idle_cnt <= '0;
        end
        S_SETTLE: settle_cnt <= settle_cnt - SW'(1);
        S_CHECK: begin
          if (adc_valid) begin
            idle_cnt <= '0;
            prev <= adc_data;
            seeded <= 1'b1;
            if (seeded) begin
              err_acc <= err_acc | (adc_data ^ (prev + DATA_WIDTH'(1)));
              samp_cnt <= samp_cnt + CW'(1);
            end
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
          if (abort) begin
            timeout <= 1'b1;
            lane_fail <= '1;
            tap_value <= '0;
            tap_load <= 1'b1;
          end
        end
        S_NEXT: begin
          for (int i = 0; i < DATA_WIDTH; i++) pass_map[i][tap] <= ~err_acc[i];
          err_acc <= '0;
          tap <= tap + TAP_WIDTH'(1);
          lane <= '0;
          atap <= '0;
          run_start <= '0;
          run_len <= '0;
          best_start <= '0;
          best_len <= '0;
        end
        S_ANALYZE: begin
          atap <= atap + TAP_WIDTH'(1);
          run_len <= cur_len;
          run_start <= cur_start;
          if (better) begin
            best_len <= cur_len;
            best_start <= cur_start;
          end
          // last tap of a lane: commit its result and restart the run tracking for the next lane
          if (atap == TAP_LAST) begin
            result[lane*TAP_WIDTH +: TAP_WIDTH] <= fin_tap;
            lane_fail[lane] <= !fin_ok;
            lane <= lane + NW'(1);
            run_len <= '0;
            best_len <= '0;
          end
        end
        S_APPLY: begin
          tap_value <= result;
          tap_load <= 1'b1;
        end
        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_idelay_calib_ctrl.sv
// tb_adc_idelay_calib_ctrl: scoreboard bench driving a tap-dependent ramp channel into the calibration sequencer
module tb_adc_idelay_calib_ctrl;
  localparam int DW = 14;
  localparam int TW = 5;
  localparam int TAPS = 32;
  localparam int LIMIT = 12000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic idelay_rdy = 1'b1;
  logic adc_valid;
  logic [DW-1:0] adc_data;
  logic [DW*TW-1:0] tap_value;
  logic tap_load, busy, done, timeout;
  logic [DW-1:0] lane_fail;

  int n_cmp = 0;
  int n_err = 0;
  logic [TAPS-1:0] good [DW];
  bit valid_en = 1'b1;
  int vprob = 100;
  logic [DW*TW-1:0] exp_q[$];
  logic [DW:0] done_q[$];

  adc_idelay_calib_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .idelay_rdy(idelay_rdy),
    .adc_valid(adc_valid), .adc_data(adc_data), .tap_value(tap_value),
    .tap_load(tap_load), .busy(busy), .done(done), .lane_fail(lane_fail),
    .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW*TW-1:0] rep(input int t);
    logic [DW*TW-1:0] r;
    for (int i = 0; i < DW; i++) r[i*TW +: TW] = TW'(t);
    return r;
  endfunction

  // Reference: per lane, the longest run of good taps (earliest on ties), centred; short runs fail.
  task automatic push_expect(input bit to);
    logic [DW*TW-1:0] fin;
    logic [DW-1:0] fail;
    int best, bs, len;
    if (to) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
      done_q.push_back({1'b1, {DW{1'b1}}});
      return;
    end
    for (int t = 0; t < TAPS; t++) exp_q.push_back(rep(t));
    fin = '0;
    fail = '0;
    for (int l = 0; l < DW; l++) begin
      best = 0;
      bs = 0;
      for (int s = 0; s < TAPS; s++) begin
        len = 0;
        while (s + len < TAPS && good[l][s+len]) len++;
        if (len > best) begin
          best = len;
          bs = s;
        end
      end
      if (best >= 4) fin[l*TW +: TW] = TW'(bs + (best - 1) / 2);
      else fail[l] = 1'b1;
    end
    exp_q.push_back(fin);
    done_q.push_back({1'b0, fail});
  endtask

  task automatic all_good;
    for (int i = 0; i < DW; i++) good[i] = '1;
  endtask

  task automatic rand_map;
    int s, l;
    for (int i = 0; i < DW; i++) begin
      if ($urandom_range(0, 3) == 0) good[i] = '1;
      else begin
        good[i] = '0;
        repeat ($urandom_range(1, 2)) begin
          s = $urandom_range(0, TAPS - 1);
          l = $urandom_range(1, 14);
          for (int t = s; t < s + l && t < TAPS; t++) good[i][t] = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input string name, input bit to, input int rdy_delay, input bit dbl);
    int n, cyc;
    push_expect(to);
    if (rdy_delay > 0) idelay_rdy = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check({name, "_busy"}, 128'(busy), 128'(1));
    n = 0;
    for (int i = 0; i < rdy_delay; i++) begin
      tick;
      n += int'(tap_load);
    end
    if (rdy_delay > 0) begin
      check({name, "_load_before_rdy"}, 128'(n), 128'(0));
      idelay_rdy = 1'b1;
    end
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      start = dbl && cyc == 5;
      tick;
      cyc++;
    end
    start = 1'b0;
    check({name, "_done"}, 128'(done), 128'(1));
    tick;
    tick;
    check({name, "_loads_left"}, 128'(exp_q.size()), 128'(0));
    check({name, "_results_left"}, 128'(done_q.size()), 128'(0));
    exp_q.delete();
    done_q.delete();
  endtask

  // Channel: lane i is corrupted while its applied tap is bad; errors are injected relative to the
  // previous word + 1, so each corrupted lane only shows up in its own bit.
  initial begin : drv
    logic [DW-1:0] d, bad, e;
    int k;
    d = DW'($urandom);
    k = 0;
    adc_valid = 1'b0;
    adc_data = '0;
    forever begin
      tick;
      if (valid_en && $urandom_range(0, 99) < vprob) begin
        for (int i = 0; i < DW; i++) bad[i] = ~good[i][tap_value[i*TW +: TW]];
        e = bad & ((k % 4 == 0) ? {DW{1'b1}} : DW'($urandom));
        d = (d + DW'(1)) ^ e;
        k++;
        adc_valid = 1'b1;
        adc_data = d;
      end else adc_valid = 1'b0;
    end
  end

  initial begin : mon
    logic done_d;
    logic [DW*TW-1:0] et;
    logic [DW:0] ed;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (tap_load) begin
        if (exp_q.size() == 0) check("unexpected_tap_load", 128'(tap_value), 128'(0) - 128'(1));
        else begin
          et = exp_q.pop_front();
          check("tap_value", 128'(tap_value), 128'(et));
        end
      end
      if (done && !done_d) begin
        if (done_q.size() == 0) check("unexpected_done", 128'(lane_fail), 128'(0) - 128'(1));
        else begin
          ed = done_q.pop_front();
          check("lane_fail", 128'(lane_fail), 128'(ed[DW-1:0]));
          check("timeout", 128'(timeout), 128'(ed[DW]));
          check("busy_at_done", 128'(busy), 128'(0));
        end
      end
      done_d = done;
    end
  end

  initial begin : main
    int n, cyc;
    all_good();
    repeat (3) tick;
    check("reset_outputs", 128'({tap_value, tap_load, busy, done, lane_fail, timeout}), 128'(0));
    reset = 1'b0;
    tick;
    run("ideal", 1'b0, 0, 1'b0);
    vprob = 80;
    all_good();
    for (int t = 0; t < TAPS; t++) if (t <= 9 || t >= 26) good[3][t] = 1'b0;
    run("lane3_window", 1'b0, 0, 1'b0);
    all_good();
    good[5] = '0;
    for (int t = 4; t <= 6; t++) good[5][t] = 1'b1;
    run("lane5_short", 1'b0, 0, 1'b0);
    all_good();
    good[0] = '0;
    for (int t = 2; t <= 7; t++) good[0][t] = 1'b1;
    for (int t = 20; t <= 25; t++) good[0][t] = 1'b1;
    run("lane0_tie", 1'b0, 0, 1'b0);
    rand_map();
    run("rdy_wait", 1'b0, 100, 1'b0);
    valid_en = 1'b0;
    run("timeout", 1'b1, 0, 1'b0);
    valid_en = 1'b1;
    all_good();
    push_expect(1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 13 && cyc < LIMIT) begin
      tick;
      n += int'(tap_load);
      cyc++;
    end
    check("reach_tap12", 128'(n), 128'(13));
    repeat (30) tick;
    reset = 1'b1;
    tick;
    check("mid_reset_outputs", 128'({tap_value, tap_load, busy, done, lane_fail, timeout}), 128'(0));
    exp_q.delete();
    done_q.delete();
    reset = 1'b0;
    tick;
    run("after_reset", 1'b0, 0, 1'b1);
    repeat (3) begin
      rand_map();
      run("random", 1'b0, 0, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
